// File: rtl/onehot_scan_decoder.sv
// Registered N-to-2^N one-hot decoder with an enable and an auto-scan mode.
// Direct mode decodes a; scan mode walks the output through every position for DWELL cycles each.
module onehot_scan_decoder #(
   parameter int N     = 2,
   parameter int DWELL = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              mode,
   input  logic              load,
   input  logic [N-1:0]      a,
   output logic [2**N-1:0]   y,
   output logic [N-1:0]      idx,
   output logic              wrap
);

   localparam int M  = 2 ** N;
   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   logic [N-1:0]  idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [M-1:0]  y_q, y_d;
   logic          wrap_q, wrap_d;

   logic [N-1:0]  sel;
   logic          show;
   logic [M-1:0]  onehot;

   // Decoder for the position that will be shown after this edge.
   for (genvar gi = 0; gi < M; gi++) begin : g_dec
      assign onehot[gi] = (sel == N'(gi));
   end

   always_comb begin
      idx_d  = idx_q;
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      sel    = idx_q;
      show   = 1'b0;
      if (en) begin
         show = 1'b1;
         if (!mode || load) begin
            idx_d = a;
            cnt_d = '0;
            sel   = a;
         end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
         end else begin
            // Dwell expired: advance, flagging the wrap from the last position back to 0.
            cnt_d  = '0;
            idx_d  = idx_q + 1'b1;
            sel    = idx_q + 1'b1;
            wrap_d = (idx_q == {N{1'b1}});
         end
      end
      y_d = show ? onehot : '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q  <= '0;
         cnt_q  <= '0;
         y_q    <= '0;
         wrap_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         cnt_q  <= cnt_d;
         y_q    <= y_d;
         wrap_q <= wrap_d;
      end
   end

   assign y    = y_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;

endmodule
